// File: rtl/uart_mem_arbiter.sv
// Arbitrates the shared memory port between UART RX-DMA (writes) and TX-DMA (reads).
// Round-robin with an RX urgency override; the memory signals follow the granted requester combinationally.
module uart_mem_arbiter #(
  parameter int M_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_req,
  input  logic [M_WIDTH-1:0] rx_addr,
  input  logic [1:0]         rx_width,
  input  logic [M_WIDTH-1:0] rx_data,
  input  logic               rx_urgent,
  output logic               rx_ready,
  input  logic               tx_req,
  input  logic [M_WIDTH-1:0] tx_addr,
  input  logic [1:0]         tx_width,
  output logic [M_WIDTH-1:0] tx_data,
  output logic               tx_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic [1:0]         mem_width,
  output logic [M_WIDTH-1:0] mem_data_out,
  input  logic               mem_ready,
  input  logic [M_WIDTH-1:0] mem_data_in,
  output logic               err_rx,
  output logic               err_tx,
  input  logic               err_clr,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, GRANT_RX, GRANT_TX} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        last_rx;
  logic        grant_req;
  logic        done;
  logic        dropped;
  logic        timeout;

  assign grant_req = (state == GRANT_RX) ? rx_req : (state == GRANT_TX) ? tx_req : 1'b0;
  assign done      = grant_req & mem_ready;
  assign dropped   = busy & ~grant_req;
  assign timeout   = grant_req & ~mem_ready & (wait_cnt == WAIT_LAST);
  assign busy      = (state != IDLE);
  assign tx_data   = mem_data_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // RX wins a tie when urgent or when TX was served last
        if (rx_req && (!tx_req || rx_urgent || !last_rx)) state_nxt = GRANT_RX;
        else if (tx_req)                                   state_nxt = GRANT_TX;
      end
      GRANT_RX, GRANT_TX: begin
        if (done || dropped || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_width    = '0;
    mem_data_out = '0;
    rx_ready     = 1'b0;
    tx_ready     = 1'b0;
    case (state)
      GRANT_RX: begin
        mem_req      = rx_req;
        mem_we       = 1'b1;
        mem_addr     = rx_addr;
        mem_width    = rx_width;
        mem_data_out = rx_data;
        rx_ready     = rx_req & mem_ready;
      end
      GRANT_TX: begin
        mem_req   = tx_req;
        mem_addr  = tx_addr;
        mem_width = tx_width;
        tx_ready  = tx_req & mem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      last_rx  <= 1'b0;
      err_rx   <= 1'b0;
      err_tx   <= 1'b0;
    end else begin
      if (!busy)           wait_cnt <= '0;
      else if (!mem_ready) wait_cnt <= wait_cnt + 16'd1;
      // A dropped request does not count as service
      if (done || timeout) last_rx <= (state == GRANT_RX);
      err_rx <= (err_rx & ~err_clr) | (timeout & (state == GRANT_RX));
      err_tx <= (err_tx & ~err_clr) | (timeout & (state == GRANT_TX));
    end
  end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter: a transaction-level model is checked every cycle,
// and literal expectations pin the key scenarios.
module tb_uart_mem_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_req = 1'b0, tx_req = 1'b0, rx_urgent = 1'b0;
  logic [W-1:0] rx_addr = '0, tx_addr = '0, rx_data = '0, mem_data_in = '0;
  logic [1:0]   rx_width = 2'd0, tx_width = 2'd0;
  logic         mem_ready = 1'b0, err_clr = 1'b0;
  logic         rx_ready, tx_ready, mem_req, mem_we, err_rx, err_tx, busy;
  logic [W-1:0] tx_data, mem_addr, mem_data_out;
  logic [1:0]   mem_width;

  int checks   = 0;
  int failures = 0;

  uart_mem_arbiter #(.M_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_req(rx_req), .rx_addr(rx_addr), .rx_width(rx_width), .rx_data(rx_data),
    .rx_urgent(rx_urgent), .rx_ready(rx_ready),
    .tx_req(tx_req), .tx_addr(tx_addr), .tx_width(tx_width), .tx_data(tx_data),
    .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_data_in(mem_data_in),
    .err_rx(err_rx), .err_tx(err_tx), .err_clr(err_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the memory (0 none, 1 RX, 2 TX), how long it has waited, who was served last.
  int m_owner   = 0;
  int m_waited  = 0;
  bit m_last_rx = 1'b0;
  bit m_err_rx  = 1'b0;
  bit m_err_tx  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_waited = 0; m_last_rx = 1'b0; m_err_rx = 1'b0; m_err_tx = 1'b0;
    end else begin
      bit still_req, set_rx, set_tx;
      set_rx = 1'b0;
      set_tx = 1'b0;
      if (m_owner == 0) begin
        m_waited = 0;
        if (rx_req && tx_req) m_owner = (rx_urgent || !m_last_rx) ? 1 : 2;
        else if (rx_req)      m_owner = 1;
        else if (tx_req)      m_owner = 2;
      end else begin
        still_req = (m_owner == 1) ? rx_req : tx_req;
        if (!still_req) begin
          m_owner = 0;
        end else if (mem_ready) begin
          m_last_rx = (m_owner == 1);
          m_owner = 0;
        end else if (m_waited + 1 >= TO) begin
          if (m_owner == 1) set_rx = 1'b1; else set_tx = 1'b1;
          m_last_rx = (m_owner == 1);
          m_owner = 0;
        end else begin
          m_waited++;
        end
      end
      m_err_rx = (m_err_rx && !err_clr) || set_rx;
      m_err_tx = (m_err_tx && !err_clr) || set_tx;
    end
  end

  always @(negedge clk) begin
    bit gr;
    gr = (m_owner == 1) ? rx_req : (m_owner == 2) ? tx_req : 1'b0;
    check("busy", busy, m_owner != 0);
    check("mem_req", mem_req, gr);
    check("mem_we", mem_we, m_owner == 1);
    check("rx_ready", rx_ready, (m_owner == 1) && rx_req && mem_ready);
    check("tx_ready", tx_ready, (m_owner == 2) && tx_req && mem_ready);
    check("tx_data", tx_data, mem_data_in);
    check("err_rx", err_rx, m_err_rx);
    check("err_tx", err_tx, m_err_tx);
    if (m_owner == 1) begin
      check("mem_addr_rx", mem_addr, rx_addr);
      check("mem_width_rx", mem_width, rx_width);
      check("mem_data_out_rx", mem_data_out, rx_data);
    end else if (m_owner == 2) begin
      check("mem_addr_tx", mem_addr, tx_addr);
      check("mem_width_tx", mem_width, tx_width);
      check("mem_data_out_tx", mem_data_out, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_seq[8] = '{0, 1, 0, 2, 0, 1, 0, 2};

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_busy", busy, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_ready", {rx_ready, tx_ready}, 0);
    check("reset_err", {err_rx, err_tx}, 0);
    step(2);
    rst = 1'b1;
    step(1);

    // Single RX write, memory answers on the third grant cycle
    rx_req = 1; rx_addr = 32'h40; rx_data = 32'hDEAD_BEEF; rx_width = 2'd2;
    #1 check("t1_idle_mem_req", mem_req, 0);
    step(1);
    check("t1_c1_mem_req", mem_req, 1);
    check("t1_c1_mem_we", mem_we, 1);
    check("t1_c1_mem_addr", mem_addr, 32'h40);
    check("t1_c1_rx_ready", rx_ready, 0);
    step(1);
    check("t1_c2_rx_ready", rx_ready, 0);
    step(1);
    mem_ready = 1;
    #1 check("t1_c3_rx_ready", rx_ready, 1);
    step(1);
    check("t1_after_busy", busy, 0);
    check("t1_after_rx_ready", rx_ready, 0);
    rx_req = 0; mem_ready = 0;
    step(1);

    // TX read returns data in the tx_ready cycle
    tx_req = 1; tx_addr = 32'h100; tx_width = 2'd1;
    step(1);
    mem_ready = 1; mem_data_in = 32'hA5;
    #1;
    check("t2_tx_data", tx_data, 32'hA5);
    check("t2_tx_ready", tx_ready, 1);
    check("t2_rx_ready", rx_ready, 0);
    check("t2_mem_we", mem_we, 0);
    check("t2_mem_addr", mem_addr, 32'h100);
    step(1);
    tx_req = 0; mem_ready = 0; mem_data_in = 0;
    step(1);

    // Continuous contention alternates with one idle cycle between grants
    rx_req = 1; tx_req = 1; mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(1);
      #1;
      check($sformatf("rr%0d_busy", i), busy, exp_seq[i] != 0);
      check($sformatf("rr%0d_rx_ready", i), rx_ready, exp_seq[i] == 1);
      check($sformatf("rr%0d_tx_ready", i), tx_ready, exp_seq[i] == 2);
    end
    rx_req = 0; tx_req = 0; mem_ready = 0;
    step(2);

    // Urgent RX beats round-robin even though RX was served last
    rx_req = 1; mem_ready = 1; rx_addr = 32'h200;
    step(1);
    check("t4_rx_ready", rx_ready, 1);
    tx_req = 1; rx_urgent = 1; tx_addr = 32'h300;
    step(1);
    check("t4_idle_busy", busy, 0);
    mem_ready = 0;
    step(1);
    check("t4_grant_we", mem_we, 1);
    check("t4_grant_addr", mem_addr, 32'h200);
    rx_req = 0; rx_urgent = 0;
    step(1);
    check("t4_drop_busy", busy, 0);

    // TX times out after TO grant cycles
    step(1);
    check("t5_grant_we", mem_we, 0);
    check("t5_grant_addr", mem_addr, 32'h300);
    check("t5_data_out", mem_data_out, 0);
    for (int c = 2; c <= TO; c++) begin
      step(1);
      check($sformatf("t5_c%0d_busy", c), busy, 1);
      check($sformatf("t5_c%0d_tx_ready", c), tx_ready, 0);
    end
    step(1);
    check("t5_timeout_busy", busy, 0);
    check("t5_err_tx", err_tx, 1);
    check("t5_tx_ready", tx_ready, 0);
    tx_req = 0; err_clr = 1;
    step(1);
    check("t5_err_tx_cleared", err_tx, 0);
    err_clr = 0;
    step(1);

    // Timeout coinciding with err_clr keeps its flag
    rx_req = 1;
    step(TO);
    err_clr = 1;
    step(1);
    check("t6_err_rx", err_rx, 1);
    check("t6_busy", busy, 0);
    rx_req = 0; err_clr = 0;
    step(1);

    // Reset mid-grant takes effect without a clock edge
    rx_req = 1;
    step(1);
    check("t7_busy", busy, 1);
    rst = 0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_mem_req", mem_req, 0);
    check("t7_rst_mem_we", mem_we, 0);
    check("t7_rst_err_rx", err_rx, 0);
    step(2);
    rst = 1;
    #1 check("t7_release_busy", busy, 0);
    step(1);
    check("t7_regrant_mem_req", mem_req, 1);
    check("t7_regrant_we", mem_we, 1);
    mem_ready = 1;
    #1 check("t7_regrant_rx_ready", rx_ready, 1);
    step(1);
    rx_req = 0; mem_ready = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mem_arbiter.md
UART_MEM_ARBITER -- requirements
Module: uart_mem_arbiter

Interface
REQ-001 Parameter M_WIDTH, default 32: width of address and data buses.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a grant waits for mem_ready before abort; legal range 1..2^16-1.
REQ-003 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset (low = reset asserted).
REQ-005 Ports rx_req / tx_req  input  1: RX-DMA / TX-DMA memory request, held until the matching ready.
REQ-006 Ports rx_addr / tx_addr  input  M_WIDTH: requester address.
REQ-007 Ports rx_width / tx_width  input  2: requester access width code.
REQ-008 Port rx_data  input  M_WIDTH: RX write data.
REQ-009 Port rx_urgent  input  1: RX FIFO near-full; raises RX priority.
REQ-010 Ports rx_ready / tx_ready  output  1: completion strobe to the granted requester.
REQ-011 Port tx_data  output  M_WIDTH: TX read data, valid when tx_ready=1.
REQ-012 Ports mem_req  output  1; mem_we  output  1; mem_addr  output  M_WIDTH; mem_width  output  2; mem_data_out  output  M_WIDTH: shared memory port.
REQ-013 Ports mem_ready  input  1; mem_data_in  input  M_WIDTH: memory completion and read data.
REQ-014 Ports err_rx / err_tx  output  1: sticky timeout flags; err_clr  input  1: clears both flags.
REQ-015 Port busy  output  1: high in any GRANT state.

Function
REQ-016 The block SHALL use a three-state FSM: IDLE, GRANT_RX, GRANT_TX.
REQ-017 In IDLE with exactly one request, the FSM SHALL move to that requester's GRANT state on the next edge.
REQ-018 In IDLE with both requests and rx_urgent=1, the FSM SHALL grant RX.
REQ-019 In IDLE with both requests and rx_urgent=0, the FSM SHALL grant the requester not served last (round-robin); last_served resets to TX, so RX wins the first tie.
REQ-020 In IDLE, mem_req SHALL be 0; latency from req assertion in IDLE to mem_req SHALL be exactly 1 cycle.
REQ-021 In GRANT_RX, mem_req=rx_req, mem_we=1, and mem_addr/mem_width/mem_data_out SHALL equal rx_addr/rx_width/rx_data combinationally.
REQ-022 In GRANT_TX, mem_req=tx_req, mem_we=0, mem_addr/mem_width SHALL equal tx_addr/tx_width, and mem_data_out=0.
REQ-023 The ready signal of the granted requester SHALL equal mem_ready (combinational); the ungranted ready SHALL be 0; tx_data SHALL equal mem_data_in.
REQ-024 When mem_ready=1 in a GRANT state, the FSM SHALL return to IDLE on that edge and update last_served to the granted requester; at least one IDLE cycle SHALL separate consecutive grants.
REQ-025 If the granted req drops before mem_ready, the FSM SHALL return to IDLE on the next edge with no ready strobe and no change to last_served.
REQ-026 A wait counter SHALL clear on grant entry and increment each GRANT cycle without mem_ready.
REQ-027 When the counter reaches TIMEOUT_CYCLES without mem_ready, the FSM SHALL return to IDLE, set err_rx or err_tx accordingly, update last_served, and issue no ready strobe.
REQ-028 If mem_ready and timeout coincide, mem_ready SHALL win (normal completion, no error).
REQ-029 err_clr SHALL clear both flags; a timeout in the same cycle as err_clr SHALL leave its flag set.
REQ-030 In GRANT states, request changes of the ungranted requester SHALL have no effect until IDLE.

Reset
REQ-031 While rst=0: FSM=IDLE, counter=0, last_served=TX, err_rx=err_tx=0, busy=0, mem_req=mem_we=0, rx_ready=tx_ready=0.
REQ-032 Reset asserted mid-grant SHALL abort immediately with no ready strobe; after release, the FSM SHALL re-arbitrate from IDLE.

Verification
REQ-033 rx_req=1 only, mem_ready on 3rd grant cycle -> mem_req high 1 cycle after req; mem_we=1; rx_ready pulses once; FSM IDLE next.
REQ-034 rx_req=tx_req=1 continuously, mem_ready=1 each grant, rx_urgent=0 -> grant order RX,TX,RX,TX, each separated by one IDLE cycle.
REQ-035 Both requesting, last_served=RX, rx_urgent=1 -> RX granted; mem_addr=rx_addr.
REQ-036 TX granted, TIMEOUT_CYCLES=4, mem_ready=0 -> return to IDLE after 4 grant cycles; err_tx=1; tx_ready never 1; err_clr pulse -> err_tx=0.
REQ-037 tx_addr=0x100, mem_data_in=0xA5 with mem_ready -> tx_data=0xA5 in the tx_ready cycle; rx_ready=0.
REQ-038 rst driven low mid-GRANT_RX -> outputs reach reset values without waiting for a clock edge; first request after release is granted through IDLE.
